// File: rtl/carpet_scroll_ctrl_pkg.sv
// Shared constants, FSM encoding and saturating-add helper for the carpet scroll controller.
package carpet_scroll_ctrl_pkg;

    localparam int unsigned PERIOD_DEF = 64;
    localparam int unsigned CNT_OUT_W  = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2,
        StWrap = 2'd3
    } state_e;

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned lim);
        return (a + b > lim) ? lim : a + b;
    endfunction

endpackage

// File: rtl/carpet_scroll_ctrl_if.sv
// Control and renderer-facing signals of one conveyor's scroll controller.
interface carpet_scroll_ctrl_if #(
    parameter int unsigned SPD_W = 3,
    parameter int unsigned LAP_W = 8
);
    import carpet_scroll_ctrl_pkg::*;

    logic                 i_vsync;
    logic                 i_enable;
    logic                 i_pause;
    logic [SPD_W-1:0]     i_speed;
    logic                 i_carpet_wrap;
    logic [CNT_OUT_W-1:0] o_carpet_count;
    logic                 o_step_pulse;
    logic                 o_wrap_pulse;
    logic [LAP_W-1:0]     o_lap_count;

    modport master (
        output i_vsync, i_enable, i_pause, i_speed, i_carpet_wrap,
        input  o_carpet_count, o_step_pulse, o_wrap_pulse, o_lap_count
    );

    modport slave (
        input  i_vsync, i_enable, i_pause, i_speed, i_carpet_wrap,
        output o_carpet_count, o_step_pulse, o_wrap_pulse, o_lap_count
    );

endinterface

// File: rtl/carpet_scroll_ctrl_frame_tick_sync.sv
// Brings raw vsync into the clock domain and emits a one-cycle tick on its rising edge.
module carpet_scroll_ctrl_frame_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vsync,
    output logic o_frame_tick
);

    logic r_meta;
    logic r_sync;
    logic r_sync_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta     <= 1'b0;
            r_sync     <= 1'b0;
            r_sync_dly <= 1'b0;
        end else begin
            r_meta     <= i_vsync;
            r_sync     <= r_meta;
            r_sync_dly <= r_sync;
        end
    end

    assign o_frame_tick = r_sync & ~r_sync_dly;

endmodule

// File: rtl/carpet_scroll_ctrl.sv
// Scroll offset generator for the carpet-stripe renderer: steps every speed+1 frames,
// clears on renderer wrap (or on a self-detected stuck-at-PERIOD), and counts laps.
module carpet_scroll_ctrl
    import carpet_scroll_ctrl_pkg::*;
#(
    parameter int unsigned PERIOD = PERIOD_DEF,
    parameter int unsigned STEP   = 1,
    parameter int unsigned SPD_W  = 3,
    parameter int unsigned LAP_W  = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    carpet_scroll_ctrl_if.slave bus
);

    localparam int unsigned     OFF_W   = $clog2(PERIOD + 1);
    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(PERIOD);

    logic             w_frame_tick;
    state_e           r_state, w_state_nxt;
    logic [SPD_W-1:0] r_presc, w_presc_nxt;
    logic [OFF_W-1:0] r_offset, w_offset_nxt;
    logic [LAP_W-1:0] r_lap;
    logic             r_step_pulse, r_wrap_pulse, r_guard;
    logic             w_step, w_wrap, w_at_max, w_guard_nxt;

    carpet_scroll_ctrl_frame_tick_sync u_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_vsync      (bus.i_vsync),
        .o_frame_tick (w_frame_tick)
    );

    assign w_at_max = (r_offset == OFF_MAX);

    always_comb begin
        w_state_nxt  = r_state;
        w_presc_nxt  = r_presc;
        w_offset_nxt = r_offset;
        w_step       = 1'b0;
        w_wrap       = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_presc_nxt  = '0;
                w_offset_nxt = '0;
                if (bus.i_enable) w_state_nxt = StRun;
            end
            StRun: begin
                if (!bus.i_enable) begin
                    w_state_nxt  = StIdle;
                    w_presc_nxt  = '0;
                    w_offset_nxt = '0;
                end else if (bus.i_carpet_wrap || (r_guard && w_at_max)) begin
                    w_state_nxt  = StWrap;
                    w_offset_nxt = '0;
                    w_wrap       = 1'b1;
                end else if (bus.i_pause) begin
                    w_state_nxt = StHold;
                end else if (w_frame_tick) begin
                    // >= also covers a speed lowered below the running prescaler
                    if (r_presc >= bus.i_speed) begin
                        w_presc_nxt  = '0;
                        w_offset_nxt = OFF_W'(sat_add(32'(r_offset), STEP, PERIOD));
                        w_step       = 1'b1;
                    end else begin
                        w_presc_nxt = r_presc + 1'b1;
                    end
                end
            end
            StHold: begin
                if (!bus.i_enable) begin
                    w_state_nxt  = StIdle;
                    w_presc_nxt  = '0;
                    w_offset_nxt = '0;
                end else if (!bus.i_pause) begin
                    w_state_nxt = StRun;
                end
            end
            StWrap: begin
                if (!bus.i_enable) begin
                    w_state_nxt  = StIdle;
                    w_presc_nxt  = '0;
                    w_offset_nxt = '0;
                end else begin
                    w_state_nxt = StRun;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Guard arms on the first unacknowledged cycle at PERIOD and fires on the second.
    assign w_guard_nxt = (r_state == StRun) && (w_state_nxt == StRun) && w_at_max && !r_guard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_offset <= '0;
        end else begin
            r_presc  <= w_presc_nxt;
            r_offset <= w_offset_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_lap <= '0;
        else if (w_wrap) r_lap <= r_lap + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_pulse <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_guard      <= 1'b0;
        end else begin
            r_step_pulse <= w_step;
            r_wrap_pulse <= w_wrap;
            r_guard      <= w_guard_nxt;
        end
    end

    assign bus.o_carpet_count = CNT_OUT_W'(r_offset);
    assign bus.o_step_pulse   = r_step_pulse;
    assign bus.o_wrap_pulse   = r_wrap_pulse;
    assign bus.o_lap_count    = r_lap;

endmodule

// File: tb/tb_carpet_scroll_ctrl.sv
// Bench for carpet_scroll_ctrl: a STEP=1 and a STEP=5 instance share stimulus and are checked
// frame by frame against a frame-level model of the offset, prescaler and lap counter.
module tb_carpet_scroll_ctrl;

    localparam int P         = 64;
    localparam int SW        = 3;
    localparam int LW        = 8;
    localparam int FRAME_CYC = 10;
    localparam int STEPS [2] = '{1, 5};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync = 1'b0;
    logic          enable = 1'b0;
    logic          pause = 1'b0;
    logic [SW-1:0] speed = '0;
    logic          rend_a = 1'b1;
    logic          rend_b = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt [2];
    int m_presc [2];
    int m_lap [2];
    int seg_steps_a = 0;
    int seg_wraps_b = 0;
    int max_seen = 0;

    always #5 clk = ~clk;

    carpet_scroll_ctrl_if #(.SPD_W(SW), .LAP_W(LW)) bus_a ();
    carpet_scroll_ctrl_if #(.SPD_W(SW), .LAP_W(LW)) bus_b ();

    assign bus_a.i_vsync       = vsync;
    assign bus_a.i_enable      = enable;
    assign bus_a.i_pause       = pause;
    assign bus_a.i_speed       = speed;
    assign bus_a.i_carpet_wrap = rend_a && (bus_a.o_carpet_count == 16'(P));
    assign bus_b.i_vsync       = vsync;
    assign bus_b.i_enable      = enable;
    assign bus_b.i_pause       = pause;
    assign bus_b.i_speed       = speed;
    assign bus_b.i_carpet_wrap = rend_b && (bus_b.o_carpet_count == 16'(P));

    carpet_scroll_ctrl #(.PERIOD(P), .STEP(1), .SPD_W(SW), .LAP_W(LW)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    carpet_scroll_ctrl #(.PERIOD(P), .STEP(5), .SPD_W(SW), .LAP_W(LW)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]   = 0;
            m_presc[i] = 0;
            m_lap[i]   = 0;
        end
    endtask

    // One vsync pulse; observe both instances every cycle, then advance the model by one frame.
    task automatic run_frame();
        int          n_step [2];
        int          n_wp [2];
        int          n_full [2];
        int          wp_ok [2];
        int          st_f, wr_f;
        logic [15:0] cnt [2];
        logic [15:0] prev [2];
        logic [LW-1:0] lap [2];
        logic        sp [2];
        logic        wp [2];
        logic        rnd [2];
        string       nm [2];
        nm = '{"A", "B"};
        rnd[0] = rend_a;
        rnd[1] = rend_b;
        n_step = '{0, 0};
        n_wp   = '{0, 0};
        n_full = '{0, 0};
        wp_ok  = '{0, 0};
        prev[0] = bus_a.o_carpet_count;
        prev[1] = bus_b.o_carpet_count;
        for (int c = 0; c < FRAME_CYC; c++) begin
            vsync = (c < 4);
            @(negedge clk);
            cnt[0] = bus_a.o_carpet_count;  cnt[1] = bus_b.o_carpet_count;
            sp[0]  = bus_a.o_step_pulse;    sp[1]  = bus_b.o_step_pulse;
            wp[0]  = bus_a.o_wrap_pulse;    wp[1]  = bus_b.o_wrap_pulse;
            lap[0] = bus_a.o_lap_count;     lap[1] = bus_b.o_lap_count;
            for (int i = 0; i < 2; i++) begin
                if (int'(cnt[i]) > max_seen) max_seen = int'(cnt[i]);
                if (cnt[i] == 16'(P)) n_full[i]++;
                if (sp[i] === 1'b1) n_step[i]++;
                if (wp[i] === 1'b1) begin
                    n_wp[i]++;
                    if (prev[i] == 16'(P) && cnt[i] == 16'd0) wp_ok[i]++;
                end
                prev[i] = cnt[i];
            end
        end
        vsync = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st_f = 0;
            wr_f = 0;
            if (!rst_n) begin
                m_cnt[i] = 0; m_presc[i] = 0; m_lap[i] = 0;
            end else if (!enable) begin
                m_cnt[i] = 0; m_presc[i] = 0;
            end else if (!pause) begin
                if (m_presc[i] >= int'(speed)) begin
                    m_presc[i] = 0;
                    m_cnt[i]   = (m_cnt[i] + STEPS[i] > P) ? P : m_cnt[i] + STEPS[i];
                    st_f       = 1;
                    if (m_cnt[i] == P) begin
                        m_cnt[i] = 0;
                        m_lap[i] = (m_lap[i] + 1) % (1 << LW);
                        wr_f     = 1;
                    end
                end else begin
                    m_presc[i]++;
                end
            end
            check({nm[i], " count"}, 32'(cnt[i]), 32'(m_cnt[i]));
            check({nm[i], " lap"}, 32'(lap[i]), 32'(m_lap[i]));
            check({nm[i], " step pulses"}, 32'(n_step[i]), 32'(st_f));
            check({nm[i], " wrap pulses"}, 32'(n_wp[i]), 32'(wr_f));
            if (wr_f == 1) begin
                check({nm[i], " cycles at PERIOD"}, 32'(n_full[i]), rnd[i] ? 32'd1 : 32'd2);
                check({nm[i], " wrap follows PERIOD"}, 32'(wp_ok[i]), 32'd1);
            end
        end
        seg_steps_a += n_step[0];
        seg_wraps_b += n_wp[1];
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Reset held: vsync activity must not move anything
        for (int f = 0; f < 3; f++) run_frame();
        check("reset count A", 32'(bus_a.o_carpet_count), 32'd0);
        check("reset lap B", 32'(bus_b.o_lap_count), 32'd0);
        rst_n = 1'b1;
        for (int f = 0; f < 3; f++) run_frame();
        check("idle count A", 32'(bus_a.o_carpet_count), 32'd0);

        // speed 0: one step per frame, wrap after the 64th
        enable = 1'b1;
        for (int f = 0; f < 64; f++) run_frame();
        check("first lap A", 32'(bus_a.o_lap_count), 32'd1);

        // speed 2: three steps in nine frames
        speed = 3'd2;
        seg_steps_a = 0;
        for (int f = 0; f < 9; f++) run_frame();
        check("speed2 steps A", 32'(seg_steps_a), 32'd3);
        check("speed2 count A", 32'(bus_a.o_carpet_count), 32'd3);
        speed = 3'd0;
        for (int f = 0; f < 7; f++) run_frame();
        check("count before pause A", 32'(bus_a.o_carpet_count), 32'd10);

        // pause freezes offset and prescaler
        pause = 1'b1;
        seg_steps_a = 0;
        for (int f = 0; f < 5; f++) run_frame();
        check("paused steps A", 32'(seg_steps_a), 32'd0);
        check("paused count A", 32'(bus_a.o_carpet_count), 32'd10);
        pause = 1'b0;
        run_frame();
        check("resume count A", 32'(bus_a.o_carpet_count), 32'd11);

        // STEP=5 instance without renderer feedback: internal guard forces the wrap
        rend_b = 1'b0;
        seg_wraps_b = 0;
        for (int f = 0; f < 13; f++) run_frame();
        check("forced wraps B", 32'(seg_wraps_b), 32'd1);
        rend_b = 1'b1;

        // Run A to lap 3, offset 37, then assert reset between clock edges
        for (int f = 0; f < 400 && !(m_lap[0] == 3 && m_cnt[0] == 37); f++) run_frame();
        check("reached 37/lap3 A", 32'(bus_a.o_carpet_count), 32'd37);
        check("lap 3 A", 32'(bus_a.o_lap_count), 32'd3);
        rst_n = 1'b0;
        #1;
        check("async reset count A", 32'(bus_a.o_carpet_count), 32'd0);
        check("async reset lap A", 32'(bus_a.o_lap_count), 32'd0);
        check("async reset lap B", 32'(bus_b.o_lap_count), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 5; f++) run_frame();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("disable clears A", 32'(bus_a.o_carpet_count), 32'd0);
        check("disable clears B", 32'(bus_b.o_carpet_count), 32'd0);
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]   = 0;
            m_presc[i] = 0;
        end

        // Randomised frames: speed changes, pauses, enable drops, renderer presence on B
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 3) == 0) speed = SW'($urandom_range(0, 7));
            pause  = ($urandom_range(0, 5) == 0);
            enable = ($urandom_range(0, 15) != 0);
            rend_b = 1'($urandom_range(0, 1));
            run_frame();
        end

        check("count never above PERIOD", 32'(max_seen <= P), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
